// File: rtl/alu_cp0_pkg.sv
// rtl/alu_cp0_pkg.sv - ALU codes, decode constants, CP0 indices and control-flag masks
package alu_cp0_pkg;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_SLTU    = 6'h2B;

    localparam logic [4:0]  CP0_RS_MF   = 5'd0;
    localparam logic [4:0]  CP0_RS_MT   = 5'd4;
    localparam logic [4:0]  CP0_STATUS  = 5'd12;
    localparam logic [4:0]  CP0_CAUSE   = 5'd13;
    localparam logic [4:0]  CP0_EPC     = 5'd14;
    localparam logic [31:0] ERET_WORD   = 32'h4200_0018;

    localparam int CTRL_IS_JAL     = 0;
    localparam int CTRL_IS_SHAMT   = 1;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_BNE_OR_BEQ = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_IS_SYSCALL = 6;
    localparam int CTRL_ZERO_EXT   = 7;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 9;
    localparam int CTRL_JUMP       = 10;
    localparam int CTRL_BRANCH     = 11;
    localparam int CTRL_REG_DST    = 12;
    localparam int CTRL_IS_JR      = 13;
    localparam int CTRL_IS_COP0    = 14;
    localparam int CTRL_READ_RS    = 15;
    localparam int CTRL_READ_RT    = 16;

    localparam logic [16:0] ONE = 17'd1;
    localparam logic [16:0] C_RTYPE   = (ONE << CTRL_REG_DST) | (ONE << CTRL_REG_WRITE)
                                      | (ONE << CTRL_READ_RS) | (ONE << CTRL_READ_RT);
    localparam logic [16:0] C_SHIFT   = (ONE << CTRL_REG_DST) | (ONE << CTRL_REG_WRITE)
                                      | (ONE << CTRL_READ_RT) | (ONE << CTRL_IS_SHAMT);
    localparam logic [16:0] C_JR      = (ONE << CTRL_IS_JR) | (ONE << CTRL_JUMP) | (ONE << CTRL_READ_RS);
    localparam logic [16:0] C_SYSCALL = (ONE << CTRL_IS_SYSCALL) | (ONE << CTRL_READ_RS) | (ONE << CTRL_READ_RT);
    localparam logic [16:0] C_IMM     = (ONE << CTRL_ALU_SRC) | (ONE << CTRL_REG_WRITE) | (ONE << CTRL_READ_RS);
    localparam logic [16:0] C_IMM_ZX  = C_IMM | (ONE << CTRL_ZERO_EXT);
    localparam logic [16:0] C_LW      = C_IMM | (ONE << CTRL_MEM_READ) | (ONE << CTRL_MEM_TO_REG);
    localparam logic [16:0] C_SW      = (ONE << CTRL_ALU_SRC) | (ONE << CTRL_MEM_WRITE)
                                      | (ONE << CTRL_READ_RS) | (ONE << CTRL_READ_RT);
    localparam logic [16:0] C_BEQ     = (ONE << CTRL_BRANCH) | (ONE << CTRL_READ_RS) | (ONE << CTRL_READ_RT);
    localparam logic [16:0] C_BNE     = C_BEQ | (ONE << CTRL_BNE_OR_BEQ);
    localparam logic [16:0] C_J       = (ONE << CTRL_JUMP);
    localparam logic [16:0] C_JAL     = (ONE << CTRL_JUMP) | (ONE << CTRL_IS_JAL) | (ONE << CTRL_REG_WRITE);
    localparam logic [16:0] C_COP0    = (ONE << CTRL_IS_COP0);

endpackage

// File: rtl/alu_cp0_control_unit_if.sv
// rtl/alu_cp0_control_unit_if.sv - ALU operand/result bundle between decoder and alu_core
interface alu_cp0_control_unit_if;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_res;
    logic        equal;

    modport master (output alu_x, output alu_y, output alu_op, input alu_res, input equal);
    modport slave  (input alu_x, input alu_y, input alu_op, output alu_res, output equal);
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU; multiplier only when ALU_CP0_MUL_EN is defined
module alu_core
    import alu_cp0_pkg::*;
(
    alu_cp0_control_unit_if.slave bus
);

    logic [31:0] res;
    logic [4:0]  sh;

    assign sh = bus.alu_y[4:0];

    // Result select; unused codes fall through to zero
    always_comb begin
        res = 32'd0;
        case (bus.alu_op)
            ALU_SLL:  res = bus.alu_x << sh;
            ALU_SRA:  res = $unsigned($signed(bus.alu_x) >>> sh);
            ALU_SRL:  res = bus.alu_x >> sh;
`ifdef ALU_CP0_MUL_EN
            ALU_MUL:  res = bus.alu_x * bus.alu_y;
`endif
            ALU_ADD:  res = bus.alu_x + bus.alu_y;
            ALU_SUB:  res = bus.alu_x - bus.alu_y;
            ALU_AND:  res = bus.alu_x & bus.alu_y;
            ALU_OR:   res = bus.alu_x | bus.alu_y;
            ALU_XOR:  res = bus.alu_x ^ bus.alu_y;
            ALU_NOR:  res = ~(bus.alu_x | bus.alu_y);
            ALU_SLT:  res = {31'd0, $signed(bus.alu_x) < $signed(bus.alu_y)};
            ALU_SLTU: res = {31'd0, bus.alu_x < bus.alu_y};
            default:  res = 32'd0;
        endcase
    end

    assign bus.alu_res = res;
    assign bus.equal   = (bus.alu_x == bus.alu_y);

endmodule

// File: rtl/alu_cp0_control_unit.sv
// rtl/alu_cp0_control_unit.sv - instruction decoder, CP0 exception unit and ALU wrapper (macro ALU_CP0_MUL_EN)
module alu_cp0_control_unit
    import alu_cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic [31:0] din,
    input  logic [2:0]  exp_src,
    input  logic [31:0] alu_x,
    input  logic [31:0] alu_y,
    output logic [31:0] alu_res,
    output logic        equal,
    output logic [16:0] ctrl,
    output logic [3:0]  alu_op,
    output logic [31:0] cp0_dout,
    output logic [31:0] pc_out,
    output logic        ex_reg_write,
    output logic        is_eret,
    output logic        has_exp,
    output logic        exp_block
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rd;
    logic [16:0] dec_ctrl;
    logic [3:0]  dec_op;
    logic        is_mfc0;
    logic        is_mtc0;

    // Status keeps IE (bit0) and the three source masks (bits 3:1) only
    logic [3:0]  status_q, status_d;
    logic [2:0]  pend_q, pend_d;
    logic [31:0] epc_q, epc_d;
    logic        block_q, block_d;

    logic [2:0]  pend_w;
    logic [2:0]  enabled;
    logic [2:0]  svc;
    logic        unused_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = instr[25:21];
    assign rd    = instr[15:11];
    assign unused_bits = ^{instr[20:16], instr[10:6], din[31:4]};

    alu_cp0_control_unit_if alu_bus ();

    assign alu_bus.alu_x  = alu_x;
    assign alu_bus.alu_y  = alu_y;
    assign alu_bus.alu_op = dec_op;
    assign alu_res        = alu_bus.alu_res;
    assign equal          = alu_bus.equal;

    alu_core u_alu (.bus(alu_bus.slave));

    // Decode op/funct into control flags and ALU operation
    always_comb begin
        dec_ctrl = '0;
        dec_op   = ALU_SLL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: begin dec_ctrl = C_RTYPE;   dec_op = ALU_ADD;  end
                    F_SUB, F_SUBU: begin dec_ctrl = C_RTYPE;   dec_op = ALU_SUB;  end
                    F_AND:         begin dec_ctrl = C_RTYPE;   dec_op = ALU_AND;  end
                    F_OR:          begin dec_ctrl = C_RTYPE;   dec_op = ALU_OR;   end
                    F_XOR:         begin dec_ctrl = C_RTYPE;   dec_op = ALU_XOR;  end
                    F_NOR:         begin dec_ctrl = C_RTYPE;   dec_op = ALU_NOR;  end
                    F_SLT:         begin dec_ctrl = C_RTYPE;   dec_op = ALU_SLT;  end
                    F_SLTU:        begin dec_ctrl = C_RTYPE;   dec_op = ALU_SLTU; end
                    F_SLL:         begin dec_ctrl = C_SHIFT;   dec_op = ALU_SLL;  end
                    F_SRL:         begin dec_ctrl = C_SHIFT;   dec_op = ALU_SRL;  end
                    F_SRA:         begin dec_ctrl = C_SHIFT;   dec_op = ALU_SRA;  end
                    F_JR:          dec_ctrl = C_JR;
                    F_SYSCALL:     dec_ctrl = C_SYSCALL;
                    default:       dec_ctrl = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin dec_ctrl = C_IMM;    dec_op = ALU_ADD;  end
            OP_SLTI:           begin dec_ctrl = C_IMM;    dec_op = ALU_SLT;  end
            OP_SLTIU:          begin dec_ctrl = C_IMM;    dec_op = ALU_SLTU; end
            OP_ANDI:           begin dec_ctrl = C_IMM_ZX; dec_op = ALU_AND;  end
            OP_ORI:            begin dec_ctrl = C_IMM_ZX; dec_op = ALU_OR;   end
            OP_XORI:           begin dec_ctrl = C_IMM_ZX; dec_op = ALU_XOR;  end
            OP_LW:             begin dec_ctrl = C_LW;     dec_op = ALU_ADD;  end
            OP_SW:             begin dec_ctrl = C_SW;     dec_op = ALU_ADD;  end
            OP_BEQ:            begin dec_ctrl = C_BEQ;    dec_op = ALU_SUB;  end
            OP_BNE:            begin dec_ctrl = C_BNE;    dec_op = ALU_SUB;  end
            OP_J:              dec_ctrl = C_J;
            OP_JAL:            dec_ctrl = C_JAL;
            OP_COP0:           dec_ctrl = C_COP0;
            default:           dec_ctrl = '0;
        endcase
    end

    assign ctrl   = dec_ctrl;
    assign alu_op = dec_op;

    assign is_mfc0      = (op == OP_COP0) && (rs == CP0_RS_MF);
    assign is_mtc0      = (op == OP_COP0) && (rs == CP0_RS_MT);
    assign is_eret      = (instr == ERET_WORD);
    assign ex_reg_write = is_mfc0;

    // Live sources count as pending in the same cycle they are raised
    assign pend_w    = pend_q | exp_src;
    assign enabled   = pend_w & status_q[3:1];
    assign svc       = enabled & (~enabled + 3'd1);
    assign has_exp   = status_q[0] & ~block_q & (|enabled);
    assign exp_block = block_q;

    // mfc0 read port; unimplemented registers read zero
    always_comb begin
        cp0_dout = 32'd0;
        if (is_mfc0) begin
            case (rd)
                CP0_STATUS: cp0_dout = {28'd0, status_q};
                CP0_CAUSE:  cp0_dout = {29'd0, pend_w};
                CP0_EPC:    cp0_dout = epc_q;
                default:    cp0_dout = 32'd0;
            endcase
        end
    end

    // Redirect: eret has priority over a simultaneous exception
    always_comb begin
        pc_out = 32'd0;
        if (is_eret)      pc_out = epc_q;
        else if (has_exp) pc_out = HANDLER_ADDR;
    end

    // CP0 next state: mtc0 writes, pending capture, exception entry and eret
    always_comb begin
        status_d = status_q;
        pend_d   = pend_w;
        epc_d    = epc_q;
        block_d  = block_q;
        if (is_mtc0) begin
            case (rd)
                CP0_STATUS: status_d = din[3:0];
                CP0_CAUSE:  pend_d   = din[2:0] | exp_src;
                CP0_EPC:    epc_d    = din;
                default:    ;
            endcase
        end
        if (is_eret) begin
            block_d = 1'b0;
        end else if (has_exp) begin
            epc_d   = pc_in;
            block_d = 1'b1;
            pend_d  = pend_d & ~svc;
        end
    end

    // CP0 register bank with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            status_q <= '0;
            pend_q   <= '0;
            epc_q    <= '0;
            block_q  <= 1'b0;
        end else begin
            status_q <= status_d;
            pend_q   <= pend_d;
            epc_q    <= epc_d;
            block_q  <= block_d;
        end
    end

endmodule

// File: tb/tb_alu_cp0_control_unit.sv
// tb/tb_alu_cp0_control_unit.sv - self-checking bench for alu_cp0_control_unit
module tb_alu_cp0_control_unit;

    localparam logic [16:0] IS_JAL   = 17'h00001;
    localparam logic [16:0] IS_SHAMT = 17'h00002;
    localparam logic [16:0] MEM2REG  = 17'h00004;
    localparam logic [16:0] REGWR    = 17'h00008;
    localparam logic [16:0] BNE      = 17'h00010;
    localparam logic [16:0] ALUSRC   = 17'h00020;
    localparam logic [16:0] SYSCALL  = 17'h00040;
    localparam logic [16:0] ZEXT     = 17'h00080;
    localparam logic [16:0] MEMRD    = 17'h00100;
    localparam logic [16:0] MEMWR    = 17'h00200;
    localparam logic [16:0] JUMP     = 17'h00400;
    localparam logic [16:0] BRANCH   = 17'h00800;
    localparam logic [16:0] REGDST   = 17'h01000;
    localparam logic [16:0] ISJR     = 17'h02000;
    localparam logic [16:0] ISCOP0   = 17'h04000;
    localparam logic [16:0] RDRS     = 17'h08000;
    localparam logic [16:0] RDRT     = 17'h10000;

    localparam logic [16:0] RR = REGDST | REGWR | RDRS | RDRT;
    localparam logic [16:0] SH = REGDST | REGWR | RDRT | IS_SHAMT;
    localparam logic [16:0] II = ALUSRC | REGWR | RDRS;

    localparam logic [31:0] MFC0_STATUS = 32'h4000_6000;
    localparam logic [31:0] MFC0_CAUSE  = 32'h4000_6800;
    localparam logic [31:0] MFC0_EPC    = 32'h4000_7000;
    localparam logic [31:0] MTC0_STATUS = 32'h4080_6000;
    localparam logic [31:0] ERET        = 32'h4200_0018;

    typedef struct {
        logic [31:0] instr;
        logic [16:0] ctrl;
        logic [3:0]  op;
    } dec_vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        eq;
    } alu_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [31:0] din;
    logic [2:0]  exp_src;
    logic [16:0] ctrl;
    logic [31:0] cp0_dout;
    logic [31:0] pc_out;
    logic        ex_reg_write;
    logic        is_eret;
    logic        has_exp;
    logic        exp_block;

    int total = 0;
    int bad   = 0;

    alu_cp0_control_unit_if bus ();

    alu_cp0_control_unit #(.HANDLER_ADDR(32'h0000_0800)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .pc_in        (pc_in),
        .din          (din),
        .exp_src      (exp_src),
        .alu_x        (bus.alu_x),
        .alu_y        (bus.alu_y),
        .alu_res      (bus.alu_res),
        .equal        (bus.equal),
        .ctrl         (ctrl),
        .alu_op       (bus.alu_op),
        .cp0_dout     (cp0_dout),
        .pc_out       (pc_out),
        .ex_reg_write (ex_reg_write),
        .is_eret      (is_eret),
        .has_exp      (has_exp),
        .exp_block    (exp_block)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_cp0(input string nm, input logic [31:0] word, input logic [31:0] exp);
        logic [31:0] save;
        save  = instr;
        instr = word;
        #1;
        chk(nm, cp0_dout, exp);
        instr = save;
        #1;
    endtask

    // Reference ALU from the operation's arithmetic meaning
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] wide;
        logic [63:0] prod;
        int          sh;
        sh = int'(y % 32);
        case (op)
            0:  ref_alu = x * (32'd1 << sh);
            1:  begin wide = {{32{x[31]}}, x} >> sh; ref_alu = wide[31:0]; end
            2:  ref_alu = x / (32'd1 << sh);
`ifdef ALU_CP0_MUL_EN
            3:  begin prod = {32'd0, x} * {32'd0, y}; ref_alu = prod[31:0]; end
`endif
            5:  ref_alu = x + y;
            6:  ref_alu = x + (~y) + 32'd1;
            7:  ref_alu = x & y;
            8:  ref_alu = x | y;
            9:  ref_alu = x ^ y;
            10: ref_alu = ~(x | y);
            11: ref_alu = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            12: ref_alu = (x < y) ? 32'd1 : 32'd0;
            default: ref_alu = 32'd0;
        endcase
        prod = 64'd0;
    endfunction

    dec_vec_t dv[$];
    alu_vec_t av[$];
    logic [31:0] rnd_instr[$];
    int          rnd_op[$];

    initial begin
        dv.push_back('{32'h0022_1820, RR, 4'd5});
        dv.push_back('{32'h0022_1823, RR, 4'd6});
        dv.push_back('{32'h0022_1824, RR, 4'd7});
        dv.push_back('{32'h0022_1825, RR, 4'd8});
        dv.push_back('{32'h0022_1826, RR, 4'd9});
        dv.push_back('{32'h0022_1827, RR, 4'd10});
        dv.push_back('{32'h0022_182A, RR, 4'd11});
        dv.push_back('{32'h0022_182B, RR, 4'd12});
        dv.push_back('{32'h0002_1080, SH, 4'd0});
        dv.push_back('{32'h0002_1082, SH, 4'd2});
        dv.push_back('{32'h0002_1083, SH, 4'd1});
        dv.push_back('{32'h03E0_0008, ISJR | JUMP | RDRS, 4'd0});
        dv.push_back('{32'h0000_000C, SYSCALL | RDRS | RDRT, 4'd0});
        dv.push_back('{32'h2001_0005, II, 4'd5});
        dv.push_back('{32'h2801_0005, II, 4'd11});
        dv.push_back('{32'h2C01_0005, II, 4'd12});
        dv.push_back('{32'h3401_0005, II | ZEXT, 4'd8});
        dv.push_back('{32'h8C01_0004, II | MEMRD | MEM2REG, 4'd5});
        dv.push_back('{32'hAC01_0004, ALUSRC | MEMWR | RDRS | RDRT, 4'd5});
        dv.push_back('{32'h1022_0003, BRANCH | RDRS | RDRT, 4'd6});
        dv.push_back('{32'h1422_0003, BRANCH | RDRS | RDRT | BNE, 4'd6});
        dv.push_back('{32'h0800_0010, JUMP, 4'd0});
        dv.push_back('{32'h0C00_0010, JUMP | IS_JAL | REGWR, 4'd0});
        dv.push_back('{32'h4001_7000, ISCOP0, 4'd0});
        dv.push_back('{32'hFC00_0000, 17'h0, 4'd0});
        dv.push_back('{32'h0000_003F, 17'h0, 4'd0});

        av.push_back('{32'h0022_1822, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0});
        av.push_back('{32'h0022_182A, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0});
        av.push_back('{32'h0022_182B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
        av.push_back('{32'h0022_1820, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
        av.push_back('{32'h0002_1083, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0});
        av.push_back('{32'h0002_1082, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0});
        av.push_back('{32'h0002_1080, 32'd1, 32'h21, 32'd2, 1'b0});
        av.push_back('{32'h0022_1827, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1});
        av.push_back('{32'h0022_1825, 32'h1234, 32'h1234, 32'h1234, 1'b1});

        rnd_instr = '{32'h0000_0000, 32'h0000_0003, 32'h0000_0002, 32'h0000_0020,
                      32'h0000_0022, 32'h0000_0024, 32'h0000_0025, 32'h0000_0026,
                      32'h0000_0027, 32'h0000_002A, 32'h0000_002B};
        rnd_op    = '{0, 1, 2, 5, 6, 7, 8, 9, 10, 11, 12};

        reset   = 1'b0;
        instr   = 32'd0;
        pc_in   = 32'd0;
        din     = 32'd0;
        exp_src = 3'd0;
        bus.alu_x = 32'd0;
        bus.alu_y = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;

        chk("rst_has_exp", {31'd0, has_exp}, 32'd0);
        chk("rst_block", {31'd0, exp_block}, 32'd0);
        rd_cp0("rst_epc", MFC0_EPC, 32'd0);
        rd_cp0("rst_status", MFC0_STATUS, 32'd0);

        for (int i = 0; i < dv.size(); i++) begin
            instr = dv[i].instr;
            #1;
            chk($sformatf("dec_ctrl[%0d]", i), {15'd0, ctrl}, {15'd0, dv[i].ctrl});
            chk($sformatf("dec_op[%0d]", i), {28'd0, bus.alu_op}, {28'd0, dv[i].op});
        end

        for (int i = 0; i < av.size(); i++) begin
            instr     = av[i].instr;
            bus.alu_x = av[i].x;
            bus.alu_y = av[i].y;
            #1;
            chk($sformatf("alu_res[%0d]", i), bus.alu_res, av[i].res);
            chk($sformatf("alu_eq[%0d]", i), {31'd0, bus.equal}, {31'd0, av[i].eq});
        end

        for (int i = 0; i < 200; i++) begin
            int k;
            k = int'($urandom_range(0, rnd_op.size() - 1));
            instr     = rnd_instr[k];
            bus.alu_x = $urandom;
            bus.alu_y = ($urandom_range(0, 7) == 0) ? bus.alu_x : $urandom;
            #1;
            chk($sformatf("rnd_res op%0d", rnd_op[k]), bus.alu_res, ref_alu(rnd_op[k], bus.alu_x, bus.alu_y));
            chk("rnd_eq", {31'd0, bus.equal}, {31'd0, bus.alu_x == bus.alu_y});
        end

        // mtc0 Status = IE | mask0
        instr = MTC0_STATUS;
        din   = 32'h3;
        #1;
        chk("mtc0_exw", {31'd0, ex_reg_write}, 32'd0);
        tick();
        instr = 32'd0;
        rd_cp0("status_rd", MFC0_STATUS, 32'h3);
        instr = MFC0_STATUS;
        #1;
        chk("mfc0_exw", {31'd0, ex_reg_write}, 32'd1);
        instr = 32'd0;

        exp_src = 3'b001;
        pc_in   = 32'h40;
        #1;
        chk("exp0_has", {31'd0, has_exp}, 32'd1);
        chk("exp0_pc", pc_out, 32'h800);
        tick();
        exp_src = 3'b000;
        #1;
        chk("exp0_block", {31'd0, exp_block}, 32'd1);
        chk("exp0_blocked", {31'd0, has_exp}, 32'd0);
        rd_cp0("exp0_epc", MFC0_EPC, 32'h40);
        rd_cp0("exp0_cause", MFC0_CAUSE, 32'd0);

        instr = ERET;
        #1;
        chk("eret_flag", {31'd0, is_eret}, 32'd1);
        chk("eret_pc", pc_out, 32'h40);
        tick();
        instr = 32'd0;
        #1;
        chk("eret_unblock", {31'd0, exp_block}, 32'd0);
        chk("idle_pc", pc_out, 32'd0);

        // Source 1 masked: pending latches but no exception
        exp_src = 3'b010;
        #1;
        chk("masked_has", {31'd0, has_exp}, 32'd0);
        tick();
        exp_src = 3'b000;
        #1;
        chk("masked_has2", {31'd0, has_exp}, 32'd0);
        rd_cp0("sticky_cause", MFC0_CAUSE, 32'h2);

        // Enable all masks; with sources 0 and 1 pending, source 0 is serviced first
        instr = MTC0_STATUS;
        din   = 32'hF;
        tick();
        instr   = 32'd0;
        exp_src = 3'b001;
        pc_in   = 32'h80;
        #1;
        chk("prio_has", {31'd0, has_exp}, 32'd1);
        tick();
        exp_src = 3'b000;
        #1;
        rd_cp0("prio_cause", MFC0_CAUSE, 32'h2);
        rd_cp0("prio_epc", MFC0_EPC, 32'h80);

        // eret and a pending exception in the same cycle: eret wins
        instr = ERET;
        tick();
        pc_in = 32'hC0;
        #1;
        chk("both_has", {31'd0, has_exp}, 32'd1);
        chk("both_pc", pc_out, 32'h80);
        tick();
        #1;
        chk("both_noblock", {31'd0, exp_block}, 32'd0);
        rd_cp0("both_epc", MFC0_EPC, 32'h80);
        instr = 32'd0;
        #1;
        chk("late_pc", pc_out, 32'h800);
        tick();
        #1;
        chk("late_block", {31'd0, exp_block}, 32'd1);
        rd_cp0("late_epc", MFC0_EPC, 32'hC0);
        rd_cp0("late_cause", MFC0_CAUSE, 32'd0);

        // Reset in the middle of an exception
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rst2_block", {31'd0, exp_block}, 32'd0);
        chk("rst2_has", {31'd0, has_exp}, 32'd0);
        rd_cp0("rst2_epc", MFC0_EPC, 32'd0);
        rd_cp0("rst2_status", MFC0_STATUS, 32'd0);
        exp_src = 3'b111;
        #1;
        chk("rst2_irq_off", {31'd0, has_exp}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cp0_control_unit.md
ALU_CP0_CONTROL_UNIT -- requirements
Module: alu_cp0_control_unit

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_0800, meaning the exception handler entry PC.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 SHALL have port instr, input, 32, the current instruction word.
REQ-005 SHALL have port pc_in, input, 32, the PC of the current instruction.
REQ-006 SHALL have port din, input, 32, the rt register data, written to CP0 by mtc0.
REQ-007 SHALL have port exp_src, input, 3, interrupt requests ExpSrc2..0, level-sensitive.
REQ-008 SHALL have port alu_x, input, 32, ALU operand sr.
REQ-009 SHALL have port alu_y, input, 32, ALU operand tg.
REQ-010 SHALL have port alu_res, output, 32, the ALU result.
REQ-011 SHALL have port equal, output, 1, asserted when alu_x equals alu_y.
REQ-012 SHALL have port ctrl, output, 17, control flags; bit0..16 are IsJAL, IsShamt, MemtoReg, RegWrite, BneOrBeq, ALUSrc, IsSyscall, ZeroExtend, MemRead, MemWrite, Jump, Branch, RegDst, IsJR, IsCOP0, ReadRs, ReadRt.
REQ-013 SHALL have port alu_op, output, 4, the decoded ALU operation.
REQ-014 SHALL have port cp0_dout, output, 32, the mfc0 read data.
REQ-015 SHALL have port pc_out, output, 32, the redirect PC.
REQ-016 SHALL have port ex_reg_write, output, 1, asserted when the register-file write enable applies to a COP0 instruction.
REQ-017 SHALL have ports is_eret, has_exp, and exp_block, each output, 1.

Function
REQ-018 ALU encoding SHALL be: 0 SLL, 1 SRA, 2 SRL, 3 MUL (low 32 bits), 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT (signed), 12 SLTU; codes 4 and 13-15 give 0.
REQ-019 Shifts SHALL shift alu_x by alu_y[4:0]; ADD and SUB wrap modulo 2^32 with no overflow trap; ALU and equal are purely combinational.
REQ-020 The decoder SHALL be combinational on instr[31:26] (op) and instr[5:0] (funct).
REQ-021 R-type instructions (op 0) SHALL decode as: add/addu, sub/subu, and, or, xor, nor, slt, sltu with RegDst, RegWrite, ReadRs, ReadRt; sll/srl/sra additionally set IsShamt and clear ReadRs.
REQ-022 jr (funct 08) SHALL set IsJR, Jump, ReadRs; syscall (funct 0C) SHALL set IsSyscall, ReadRs, ReadRt.
REQ-023 I-type instructions SHALL decode as: addi/addiu 08/09, slti/sltiu 0A/0B, andi/ori/xori 0C/0D/0E with ZeroExtend; each sets ALUSrc, RegWrite, ReadRs.
REQ-024 lw (23) SHALL set MemRead and MemtoReg; sw (2B) SHALL set MemWrite and ReadRt; both use ADD with ALUSrc.
REQ-025 beq (04) and bne (05) SHALL set Branch, ReadRs, ReadRt, and SUB; BneOrBeq=1 for bne.
REQ-026 j (02) SHALL set Jump; jal (03) SHALL set Jump, IsJAL, RegWrite.
REQ-027 op 10 SHALL set IsCOP0; any unlisted op or funct SHALL give all-zero ctrl and alu_op 0.
REQ-028 CP0 SHALL hold Status (reg 12: bit0 IE, bits 3:1 masks), Cause (reg 13: bits 2:0 pending), and EPC (reg 14).
REQ-029 mfc0 (rs=0) SHALL give cp0_dout = CP0[rd] and ex_reg_write=1; unimplemented rd SHALL read 0.
REQ-030 mtc0 (rs=4) SHALL write din to CP0[rd] at the clock edge; ex_reg_write=0.
REQ-031 is_eret SHALL be 1 when instr == 32'h4200_0018.
REQ-032 Cause pending bit i SHALL set while exp_src[i]=1 and clear when that source is serviced.
REQ-033 has_exp SHALL be combinational: IE & ~exp_block & |(pending & mask).
REQ-034 On has_exp the edge SHALL do EPC<=pc_in, exp_block<=1, and clear the highest-priority pending bit (bit0 highest).
REQ-035 pc_out SHALL be HANDLER_ADDR when has_exp, EPC when is_eret, else 0.
REQ-036 eret SHALL clear exp_block at the edge; if eret and has_exp occur in the same cycle, eret wins and no exception is taken.

Reset
REQ-037 reset=0 at an edge SHALL clear Status, Cause, EPC, and exp_block, so has_exp=0 and interrupts are disabled after reset.

Configuration
REQ-038 With macro ALU_CP0_MUL_EN defined, ALUop 3 SHALL give the low product; undefined, ALUop 3 SHALL give 0 and no multiplier is synthesised.

Structure
REQ-039 Package alu_cp0_pkg SHALL hold the ALUop codes, opcode and funct constants, CP0 register indices, and ctrl bit positions.
REQ-040 The ALU SHALL be a sub-module named alu_core; the decoder and CP0 live in the top level.

Verification
REQ-041 ALU: x=5, y=7, SUB gives FFFF_FFFE and equal=0; SLT of FFFF_FFFF vs 1 gives 1; SLTU of the same gives 0.
REQ-042 Decode: instr 8C01_0004 (lw) gives MemRead=MemtoReg=ALUSrc=RegWrite=1 and alu_op=5; unknown op 3F gives all-zero ctrl.
REQ-043 CP0: mtc0 din=0000_0003 to reg 12, then exp_src=001 with pc_in=0000_0040 gives has_exp=1 and pc_out=0000_0800; next cycle EPC=40 and exp_block=1.
REQ-044 CP0: with exp_block set, eret gives pc_out=0000_0040, then exp_block=0; mask bit clear means has_exp stays 0.
REQ-045 Reset: reset=0 mid-exception clears EPC and exp_block at the next edge.
